// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction formats, control-bit order
// and the ID-stage FSM state type.
package rv_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_BAD
    } fmt_t;

    // Field order, MSB first, of the registered control bundle.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } id_state_t;

    function automatic fmt_t opcode_fmt(input logic [6:0] op);
        case (op)
            OP_R:              return FMT_R;
            OP_I_ALU, OP_LOAD: return FMT_I;
            OP_STORE:          return FMT_S;
            OP_BRANCH:         return FMT_B;
            OP_JAL:            return FMT_J;
            default:           return FMT_BAD;
        endcase
    endfunction

    function automatic logic fmt_reads_rs1(input fmt_t f);
        return (f == FMT_R) || (f == FMT_I) || (f == FMT_S) || (f == FMT_B);
    endfunction

    function automatic logic fmt_reads_rs2(input fmt_t f);
        return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write
// port, x0 hard-wired to zero, and same-cycle write-through to both read ports.
module reg_file
    import rv_pkg::*;
#(
    parameter int Reg_Count  = 32,
    parameter int Data_Width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [Data_Width-1:0] rs1_data,
    output logic [Data_Width-1:0] rs2_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [Data_Width-1:0] wb_data
);

    logic [Data_Width-1:0] regs [Reg_Count];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Reg_Count; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // The bypass lets WB and ID share a cycle without a read-after-write hazard.
    assign rs1_data = (rs1_addr == '0)                   ? '0      :
                      (wb_en && wb_addr == rs1_addr)     ? wb_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0)                   ? '0      :
                      (wb_en && wb_addr == rs2_addr)     ? wb_data : regs[rs2_addr];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: RV32I subset decode, immediate generation, register
// read, and a RUN/BUBBLE FSM that inserts one bubble per load-use hazard.
module id_stage
    import rv_pkg::*;
#(
    parameter int Reg_Count  = 32,
    parameter int Data_Width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Inst_In,
    input  logic [31:0]           PC_In,
    input  logic                  isBranchTaken,
    input  logic                  WB_En,
    input  logic [4:0]            WB_Addr,
    input  logic [Data_Width-1:0] WB_Data,
    output logic                  Stall_Out,
    output logic                  Valid_Out,
    output logic [Data_Width-1:0] Rs1_Data,
    output logic [Data_Width-1:0] Rs2_Data,
    output logic [Data_Width-1:0] Imm_Out,
    output logic [31:0]           PC_Out,
    output logic [4:0]            Rd_Out,
    output logic [2:0]            Funct3_Out,
    output logic                  Funct7b5_Out,
    output logic                  RegWrite_Out,
    output logic                  MemRead_Out,
    output logic                  MemWrite_Out,
    output logic                  Branch_Out,
    output logic                  Jump_Out,
    output logic                  ALUSrc_Out,
    output logic                  Illegal_Out,
    output id_state_t             state_dbg
);

    logic [6:0]            opcode;
    logic [4:0]            rs1, rs2;
    fmt_t                  fmt;
    ctrl_t                 dec_ctrl, ctrl_q;
    logic [Data_Width-1:0] dec_imm;
    logic [4:0]            dec_rd;
    logic [2:0]            dec_f3;
    logic                  dec_f7b5;
    logic [Data_Width-1:0] rf_rs1, rf_rs2;
    logic                  load_use, take_bubble;
    id_state_t             state_q, state_d;

    assign opcode = Inst_In[6:0];
    assign rs1    = Inst_In[19:15];
    assign rs2    = Inst_In[24:20];
    assign fmt    = opcode_fmt(opcode);

    reg_file #(.Reg_Count(Reg_Count), .Data_Width(Data_Width)) u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rf_rs1),
        .rs2_data (rf_rs2),
        .wb_en    (WB_En),
        .wb_addr  (WB_Addr),
        .wb_data  (WB_Data)
    );

    always_comb begin
        dec_ctrl = CTRL_NONE;
        dec_imm  = '0;
        dec_rd   = '0;
        dec_f3   = '0;
        dec_f7b5 = 1'b0;
        case (fmt)
            FMT_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_rd   = Inst_In[11:7];
                dec_f3   = Inst_In[14:12];
                dec_f7b5 = Inst_In[30];
            end
            FMT_I: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_read  = (opcode == OP_LOAD);
                dec_rd   = Inst_In[11:7];
                dec_f3   = Inst_In[14:12];
                // Only SRAI/SRLI carry an ALU qualifier in the immediate field.
                dec_f7b5 = (opcode == OP_I_ALU) && (Inst_In[14:12] == 3'b101) && Inst_In[30];
                dec_imm  = {{20{Inst_In[31]}}, Inst_In[31:20]};
            end
            FMT_S: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_f3  = Inst_In[14:12];
                dec_imm = {{20{Inst_In[31]}}, Inst_In[31:25], Inst_In[11:7]};
            end
            FMT_B: begin
                dec_ctrl.branch = 1'b1;
                dec_f3  = Inst_In[14:12];
                dec_imm = {{19{Inst_In[31]}}, Inst_In[31], Inst_In[7],
                           Inst_In[30:25], Inst_In[11:8], 1'b0};
            end
            FMT_J: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_rd  = Inst_In[11:7];
                dec_imm = {{11{Inst_In[31]}}, Inst_In[31], Inst_In[19:12],
                           Inst_In[20], Inst_In[30:21], 1'b0};
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
    end

    // Hazard compares the load currently on the outputs against the fields the
    // held instruction really reads; JAL and garbage fields never stall.
    assign load_use = Valid_Out && ctrl_q.mem_read && (Rd_Out != '0) &&
                      ((fmt_reads_rs1(fmt) && Rd_Out == rs1) ||
                       (fmt_reads_rs2(fmt) && Rd_Out == rs2));

    // Stall_Out is a hold request: while high, IF keeps PC_In and Inst_In stable.
    assign Stall_Out = !reset && !isBranchTaken && (state_q == ST_RUN) && load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = ST_RUN;
        take_bubble = isBranchTaken || Stall_Out;
        if (Stall_Out) begin
            state_d = ST_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || take_bubble) begin
            Valid_Out    <= 1'b0;
            ctrl_q       <= CTRL_NONE;
            Rd_Out       <= '0;
            Funct3_Out   <= '0;
            Funct7b5_Out <= 1'b0;
            Rs1_Data     <= '0;
            Rs2_Data     <= '0;
            Imm_Out      <= '0;
            PC_Out       <= '0;
        end else begin
            Valid_Out    <= 1'b1;
            ctrl_q       <= dec_ctrl;
            Rd_Out       <= dec_rd;
            Funct3_Out   <= dec_f3;
            Funct7b5_Out <= dec_f7b5;
            Rs1_Data     <= rf_rs1;
            Rs2_Data     <= rf_rs2;
            Imm_Out      <= dec_imm;
            PC_Out       <= PC_In;
        end
    end

    assign RegWrite_Out = ctrl_q.reg_write;
    assign MemRead_Out  = ctrl_q.mem_read;
    assign MemWrite_Out = ctrl_q.mem_write;
    assign Branch_Out   = ctrl_q.branch;
    assign Jump_Out     = ctrl_q.jump;
    assign ALUSrc_Out   = ctrl_q.alu_src;
    assign Illegal_Out  = ctrl_q.illegal;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then randomized instruction streams,
// checked against a field-level instruction model and register-file array.
module tb_id_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst_In, PC_In;
  logic        isBranchTaken;
  logic        WB_En;
  logic [4:0]  WB_Addr;
  logic [31:0] WB_Data;
  logic        Stall_Out, Valid_Out;
  logic [31:0] Rs1_Data, Rs2_Data, Imm_Out, PC_Out;
  logic [4:0]  Rd_Out;
  logic [2:0]  Funct3_Out;
  logic        Funct7b5_Out;
  logic        RegWrite_Out, MemRead_Out, MemWrite_Out, Branch_Out, Jump_Out, ALUSrc_Out, Illegal_Out;
  id_state_t   state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  id_stage dut (
    .clk(clk), .reset(reset), .Inst_In(Inst_In), .PC_In(PC_In),
    .isBranchTaken(isBranchTaken), .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
    .Stall_Out(Stall_Out), .Valid_Out(Valid_Out), .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
    .Imm_Out(Imm_Out), .PC_Out(PC_Out), .Rd_Out(Rd_Out), .Funct3_Out(Funct3_Out),
    .Funct7b5_Out(Funct7b5_Out), .RegWrite_Out(RegWrite_Out), .MemRead_Out(MemRead_Out),
    .MemWrite_Out(MemWrite_Out), .Branch_Out(Branch_Out), .Jump_Out(Jump_Out),
    .ALUSrc_Out(ALUSrc_Out), .Illegal_Out(Illegal_Out), .state_dbg(state_dbg)
  );

  // control bundle bits: {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
  localparam logic [6:0] C_RW = 7'b1000000;
  localparam logic [6:0] C_MR = 7'b0100000;
  localparam logic [6:0] C_MW = 7'b0010000;
  localparam logic [6:0] C_BR = 7'b0001000;
  localparam logic [6:0] C_JP = 7'b0000100;
  localparam logic [6:0] C_AS = 7'b0000010;
  localparam logic [6:0] C_IL = 7'b0000001;

  // An instruction as the generator intends it, with its expected decode.
  typedef struct packed {
    logic [31:0] word;
    logic [6:0]  ctrl;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic        use1, use2, chk_f3, chk_f7, chk_imm;
  } ins_t;

  typedef struct packed {
    logic        valid;
    logic [6:0]  ctrl;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] rs1_d, rs2_d, imm, pc;
    logic        chk_f3, chk_f7, chk_imm, chk_rs1, chk_rs2;
    logic        bubble_st;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  logic [31:0] m_regs [32];
  logic        m_bubble, m_valid, m_memread;
  logic [4:0]  m_rd;
  logic [31:0] pc;
  int          n_checks, n_fail;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic ins_t mk_r(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [2:0] f3, input logic f7b5);
    ins_t t = '0;
    t.word = {1'b0, f7b5, 5'b0, r2, r1, f3, rd, 7'b0110011};
    t.ctrl = C_RW; t.rd = rd; t.rs1 = r1; t.rs2 = r2; t.f3 = f3; t.f7b5 = f7b5;
    t.use1 = 1'b1; t.use2 = 1'b1; t.chk_f3 = 1'b1; t.chk_f7 = 1'b1; t.chk_imm = 1'b1;
    return t;
  endfunction

  function automatic ins_t mk_i(input logic [4:0] rd, input logic [4:0] r1, input logic [2:0] f3,
                                input int imm, input logic is_load);
    ins_t t = '0;
    logic [31:0] iv = imm;
    t.word = {iv[11:0], r1, (is_load ? 3'b010 : f3), rd, (is_load ? 7'b0000011 : 7'b0010011)};
    t.ctrl = is_load ? (C_RW | C_MR | C_AS) : (C_RW | C_AS);
    t.rd = rd; t.rs1 = r1; t.f3 = is_load ? 3'b010 : f3; t.imm = iv;
    t.use1 = 1'b1; t.chk_f3 = 1'b1; t.chk_imm = 1'b1;
    return t;
  endfunction

  function automatic ins_t mk_s(input logic [4:0] r1, input logic [4:0] r2, input int imm);
    ins_t t = '0;
    logic [31:0] iv = imm;
    t.word = {iv[11:5], r2, r1, 3'b010, iv[4:0], 7'b0100011};
    t.ctrl = C_MW | C_AS; t.rs1 = r1; t.rs2 = r2; t.f3 = 3'b010; t.imm = iv;
    t.use1 = 1'b1; t.use2 = 1'b1; t.chk_f3 = 1'b1; t.chk_imm = 1'b1;
    return t;
  endfunction

  function automatic ins_t mk_b(input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                                input int imm);
    ins_t t = '0;
    logic [31:0] iv = imm;
    t.word = {iv[12], iv[10:5], r2, r1, f3, iv[4:1], iv[11], 7'b1100011};
    t.ctrl = C_BR; t.rs1 = r1; t.rs2 = r2; t.f3 = f3; t.imm = iv;
    t.use1 = 1'b1; t.use2 = 1'b1; t.chk_f3 = 1'b1; t.chk_imm = 1'b1;
    return t;
  endfunction

  function automatic ins_t mk_j(input logic [4:0] rd, input int imm);
    ins_t t = '0;
    logic [31:0] iv = imm;
    t.word = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'b1101111};
    t.ctrl = C_JP | C_RW; t.rd = rd; t.imm = iv; t.chk_imm = 1'b1;
    return t;
  endfunction

  function automatic ins_t mk_bad(input logic [6:0] op, input logic [24:0] upper);
    ins_t t = '0;
    t.word = {upper, op};
    t.ctrl = C_IL;
    return t;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  // ---------------- driver ----------------
  task automatic step(input ins_t ins, input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rst, output logic stalled);
    exp_t e, got;
    logic exp_stall;
    Inst_In = ins.word; PC_In = pc; isBranchTaken = fl;
    WB_En = we; WB_Addr = wa; WB_Data = wd; reset = rst;
    #1;
    exp_stall = !rst && !fl && !m_bubble && m_valid && m_memread && (m_rd != 5'd0) &&
                ((ins.use1 && m_rd == ins.rs1) || (ins.use2 && m_rd == ins.rs2));
    check("stall", 64'(Stall_Out), 64'(exp_stall));

    e = '0;
    e.chk_f3 = 1'b1; e.chk_f7 = 1'b1; e.chk_imm = 1'b1; e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1;
    if (rst) begin
      m_bubble = 1'b0;
    end else if (fl || exp_stall) begin
      m_bubble = exp_stall;
      e.bubble_st = exp_stall;
    end else begin
      m_bubble = 1'b0;
      e.valid = 1'b1; e.ctrl = ins.ctrl; e.rd = ins.rd; e.f3 = ins.f3; e.f7b5 = ins.f7b5;
      e.imm = ins.imm; e.pc = pc;
      e.chk_f3 = ins.chk_f3; e.chk_f7 = ins.chk_f7; e.chk_imm = ins.chk_imm;
      e.chk_rs1 = ins.use1; e.chk_rs2 = ins.use2;
      e.rs1_d = ins.use1 ? m_read(ins.rs1, we, wa, wd) : 32'd0;
      e.rs2_d = ins.use2 ? m_read(ins.rs2, we, wa, wd) : 32'd0;
    end
    exp_q.push_back(e);

    @(posedge clk); #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      m_regs[wa] = wd;
    end

    got = exp_q.pop_front();
    check("valid", 64'(Valid_Out), 64'(got.valid));
    check("ctrl", 64'({RegWrite_Out, MemRead_Out, MemWrite_Out, Branch_Out, Jump_Out,
                       ALUSrc_Out, Illegal_Out}), 64'(got.ctrl));
    check("rd", 64'(Rd_Out), 64'(got.rd));
    check("pc", 64'(PC_Out), 64'(got.pc));
    check("state", 64'(state_dbg), 64'(got.bubble_st));
    if (got.chk_f3)  check("funct3", 64'(Funct3_Out), 64'(got.f3));
    if (got.chk_f7)  check("funct7b5", 64'(Funct7b5_Out), 64'(got.f7b5));
    if (got.chk_imm) check("imm", 64'(Imm_Out), 64'(got.imm));
    if (got.chk_rs1) check("rs1_data", 64'(Rs1_Data), 64'(got.rs1_d));
    if (got.chk_rs2) check("rs2_data", 64'(Rs2_Data), 64'(got.rs2_d));

    m_valid   = got.valid;
    m_memread = got.ctrl[5];
    m_rd      = got.rd;
    stalled   = exp_stall;
    if (!exp_stall) pc = pc + 32'd1;
  endtask

  task automatic go(input ins_t ins);
    logic st;
    step(ins, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, st);
    if (st) step(ins, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, st);
  endtask

  // Randomized issue; a stalled instruction is held once, as IF would.
  task automatic issue(input ins_t ins);
    logic st, fl, we, rst;
    logic [4:0]  wa;
    logic [31:0] wd;
    for (int k = 0; k < 2; k++) begin
      fl  = ($urandom_range(0, 9) == 0);
      we  = $urandom_range(0, 1);
      wa  = 5'($urandom_range(0, 7));
      wd  = $urandom;
      rst = ($urandom_range(0, 149) == 0);
      step(ins, fl, we, wa, wd, rst, st);
      if (!st) break;
    end
  endtask

  function automatic ins_t rand_ins();
    logic [4:0] rd, r1, r2;
    logic [6:0] op;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0: return mk_r(rd, r1, r2, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      1: return mk_i(rd, r1, 3'($urandom_range(0, 7)), $urandom_range(0, 4095) - 2048, 1'b0);
      2: return mk_i(rd, r1, 3'b010, $urandom_range(0, 4095) - 2048, 1'b1);
      3: return mk_s(r1, r2, $urandom_range(0, 4095) - 2048);
      4: return mk_b(r1, r2, 3'($urandom_range(0, 1)), 2 * ($urandom_range(0, 4095) - 2048));
      5: return mk_j(rd, 2 * ($urandom_range(0, 1048575) - 524288));
      default: begin
        op = 7'($urandom);
        if (op == OP_R || op == OP_I_ALU || op == OP_LOAD || op == OP_STORE ||
            op == OP_BRANCH || op == OP_JAL) op = 7'h7F;
        return mk_bad(op, 25'($urandom));
      end
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic st;
    ins_t nop, add5;
    n_checks = 0; n_fail = 0; pc = 32'd0;
    m_bubble = 1'b0; m_valid = 1'b0; m_memread = 1'b0; m_rd = 5'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    Inst_In = 32'd0; PC_In = 32'd0; isBranchTaken = 1'b0;
    WB_En = 1'b0; WB_Addr = 5'd0; WB_Data = 32'd0; reset = 1'b1;
    nop  = mk_i(5'd0, 5'd0, 3'd0, 0, 1'b0);
    add5 = mk_r(5'd5, 5'd2, 5'd2, 3'd0, 1'b0);

    // reset, with a writeback and flush that reset must override
    step(nop, 1'b1, 1'b1, 5'd9, 32'hAAAA5555, 1'b1, st);
    step(nop, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, st);
    go(mk_r(5'd8, 5'd9, 5'd0, 3'd0, 1'b0));                      // x9 stayed 0

    go(mk_i(5'd1, 5'd0, 3'd0, 5, 1'b0));                         // ADDI x1,x0,5
    step(mk_r(5'd4, 5'd3, 5'd0, 3'd0, 1'b0), 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, st);
    step(mk_r(5'd6, 5'd0, 5'd0, 3'd0, 1'b0), 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, st);
    go(mk_r(5'd7, 5'd0, 5'd3, 3'd0, 1'b1));                      // x0 reads 0, x3 stored

    go(mk_i(5'd2, 5'd1, 3'd2, 0, 1'b1));                         // LW x2,0(x1)
    go(add5);                                                    // stall, bubble, ADD
    go(mk_i(5'd2, 5'd1, 3'd2, 0, 1'b1));
    go(mk_j(5'd2, 32'h10000));                                   // JAL: no stall
    go(mk_i(5'd2, 5'd1, 3'd2, 0, 1'b1));
    step(add5, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);               // flush beats hazard
    go(mk_s(5'd2, 5'd1, -4));                                    // 0xFE112E23
    go(mk_b(5'd1, 5'd2, 3'd1, -4096));
    go(mk_bad(7'h7F, 25'h1ABCDEF));

    go(mk_i(5'd2, 5'd1, 3'd2, 8, 1'b1));
    step(add5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, st);               // enters BUBBLE
    step(add5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, st);               // reset mid-bubble
    go(add5);                                                    // no residual stall

    for (int n = 0; n < 400; n++) issue(rand_ins());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter Reg_Count, 32, number of architectural registers (x0..x31).
REQ-002 Parameter Data_Width, 32, register and immediate width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Inst_In  input  32  instruction fetched by IF, registered output of IF.
REQ-006 PC_In  input  32  word address of Inst_In (IF increments PC by 1 per instruction).
REQ-007 isBranchTaken  input  1  flush request from EX; the same signal that redirects IF.
REQ-008 WB_En / WB_Addr / WB_Data  input  1/5/32  writeback port from WB stage.
REQ-009 Stall_Out  output  1  combinational; upstream holds PC and Inst_In while high.
REQ-010 Valid_Out  output  1  registered; the decoded bundle is a real instruction.
REQ-011 Rs1_Data / Rs2_Data / Imm_Out / PC_Out  output  32 each  registered operands, sign-extended immediate, passed-through PC.
REQ-012 Rd_Out / Funct3_Out / Funct7b5_Out  output  5/3/1  registered destination and ALU qualifiers.
REQ-013 RegWrite_Out, MemRead_Out, MemWrite_Out, Branch_Out, Jump_Out, ALUSrc_Out, Illegal_Out  output  1 each  registered control bits.

Function
REQ-014 Decode SHALL support the RV32I subset: R-type 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BEQ/BNE 1100011, JAL 1101111.
REQ-015 Latency SHALL be 1 cycle: Inst_In present before edge N appears decoded on the outputs after edge N.
REQ-016 Imm_Out SHALL be built from the I/S/B/J formats with bit 31 sign-extended; B/J immediates remain byte offsets (EX converts them); R-type gives 0.
REQ-017 Register file: Reg_Count x Data_Width; x0 reads 0 always; a write occurs at posedge when WB_En=1 and WB_Addr!=0.
REQ-018 Same-cycle read of WB_Addr (nonzero, WB_En=1) SHALL return WB_Data (write-through bypass).
REQ-019 Unknown opcode: Illegal_Out=1, Valid_Out=1, all other control bits 0, Rd_Out=0.
REQ-020 Load-use hazard: Stall_Out=1 when Valid_Out=1, MemRead_Out=1, Rd_Out!=0, and Rd_Out equals an rs field that Inst_In's format actually reads (rs1 for I/S/B/R; rs2 for S/B/R).
REQ-021 FSM has states RUN and BUBBLE; a hazard in RUN moves to BUBBLE and captures a bubble (Valid_Out=0, all control 0); BUBBLE returns to RUN unconditionally next edge and decodes the held Inst_In.
REQ-022 Stall_Out SHALL be 0 in BUBBLE; the maximum stall is 1 cycle per load.
REQ-023 isBranchTaken=1 at an edge SHALL capture a bubble, force the state to RUN, and override the stall; Stall_Out is gated to 0 while isBranchTaken=1.
REQ-024 A bubble SHALL drive Rd_Out=0, Illegal_Out=0, and zero data outputs.

Reset
REQ-025 On reset: all registered outputs are 0, the state is RUN, and Stall_Out is 0.
REQ-026 Register-file contents SHALL be cleared to 0 on reset.
REQ-027 Reset SHALL take priority over flush, stall, and writeback in the same cycle.
REQ-028 Reset mid-BUBBLE SHALL return to RUN with no residual stall.

Structure
REQ-029 Opcode constants, format identifiers, and the control-bit field order SHALL live in the shared package rv_pkg.
REQ-030 The register file SHALL be the sub-module reg_file (2 async read ports, 1 sync write port, bypass inside).
REQ-031 Decode/immediate logic and the FSM SHALL stay in id_stage; the target is 150-300 lines.

Verification
REQ-032 Scenario: reset, then ADDI x1,x0,5 (0x00500093) -> next cycle Valid_Out=1, RegWrite_Out=1, ALUSrc_Out=1, Rd_Out=1, Imm_Out=5.
REQ-033 Scenario: WB_En=1, WB_Addr=3, WB_Data=0xDEADBEEF in the same cycle as ADD x4,x3,x0 -> Rs1_Data=0xDEADBEEF; a write to x0 is then read back as 0.
REQ-034 Scenario: LW x2,0(x1) followed by ADD x5,x2,x2 -> Stall_Out=1 for one cycle, one bubble, then ADD decoded with Rd_Out=5; no stall when the consumer is JAL.
REQ-035 Scenario: isBranchTaken=1 concurrent with a load-use hazard -> Stall_Out=0, next Valid_Out=0, state RUN.
REQ-036 Scenario: SW with imm=-4 (0xFE112E23) -> Imm_Out=0xFFFFFFFC, MemWrite_Out=1; opcode 0x7F -> Illegal_Out=1.
REQ-037 Scenario: reset asserted during BUBBLE -> all outputs 0 next cycle.
